// File: rtl/line_fill_buffer.sv
// Line fill buffer: assembles one cache line from a byte-wide beat stream,
// critical byte first with wrap-around, and forwards the critical byte early.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; line_data holds the last assembled line
// S_FILL | accepting beats into lane[ptr]; abort returns to S_IDLE
// S_DONE | single cycle with line_done high; always returns to S_IDLE
module line_fill_buffer #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 16,
    parameter int OFF_W  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [OFF_W-1:0]        start_offset_i,
    input  logic                    abort_i,
    input  logic                    beat_valid_i,
    input  logic [DATA_W-1:0]       beat_data_i,
    output logic                    beat_ready_o,
    output logic                    busy_o,
    output logic [BEATS*DATA_W-1:0] line_data_o,
    output logic [BEATS-1:0]        byte_mask_o,
    output logic                    crit_valid_o,
    output logic [DATA_W-1:0]       crit_data_o,
    output logic                    line_done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);

    state_e                  state_q, state_d;
    logic [OFF_W-1:0]        ptr_q, ptr_d;
    logic [OFF_W-1:0]        count_q, count_d;
    logic [BEATS*DATA_W-1:0] line_q, line_d;
    logic [BEATS-1:0]        mask_q, mask_d;
    logic [DATA_W-1:0]       crit_q, crit_d;
    logic                    crit_valid_q, crit_valid_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        line_d       = line_q;
        mask_d       = mask_q;
        crit_d       = crit_q;
        crit_valid_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d   = start_offset_i;
                    count_d = '0;
                    mask_d  = '0;
                    line_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Abort has priority, even over the final beat.
                if (abort_i) begin
                    mask_d  = '0;
                    state_d = S_IDLE;
                end else if (beat_valid_i) begin
                    line_d[int'(ptr_q)*DATA_W +: DATA_W] = beat_data_i;
                    mask_d[ptr_q] = 1'b1;
                    ptr_d         = ptr_q + OFF_W'(1);
                    count_d       = count_q + OFF_W'(1);
                    if (count_q == '0) begin
                        crit_d       = beat_data_i;
                        crit_valid_d = 1'b1;
                    end
                    if (count_q == LAST_BEAT) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            line_q       <= '0;
            mask_q       <= '0;
            crit_q       <= '0;
            crit_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            line_q       <= line_d;
            mask_q       <= mask_d;
            crit_q       <= crit_d;
            crit_valid_q <= crit_valid_d;
            done_q       <= done_d;
        end
    end

    assign busy_o       = (state_q == S_FILL);
    assign beat_ready_o = (state_q == S_FILL) && !abort_i;
    assign line_data_o  = line_q;
    assign byte_mask_o  = mask_q;
    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_q;
    assign line_done_o  = done_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: aligned, wrapped, throttled, aborted,
// reset-interrupted fills and ignored start requests.
module tb_line_fill_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   start_offset;
    logic         abort;
    logic         beat_valid;
    logic [7:0]   beat_data;
    logic         beat_ready;
    logic         busy;
    logic [127:0] line_data;
    logic [15:0]  byte_mask;
    logic         crit_valid;
    logic [7:0]   crit_data;
    logic         line_done;

    int n_tests = 0;
    int n_fail  = 0;

    line_fill_buffer #(.DATA_W(8), .BEATS(16), .OFF_W(4)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .start_offset_i (start_offset),
        .abort_i        (abort),
        .beat_valid_i   (beat_valid),
        .beat_data_i    (beat_data),
        .beat_ready_o   (beat_ready),
        .busy_o         (busy),
        .line_data_o    (line_data),
        .byte_mask_o    (byte_mask),
        .crit_valid_o   (crit_valid),
        .crit_data_o    (crit_data),
        .line_done_o    (line_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_line(input logic [3:0] off, input logic [7:0] base);
        logic [127:0] r;
        logic [3:0]   idx;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            idx = 4'(int'(off) + k);
            r[int'(idx)*8 +: 8] = base + 8'(k);
        end
        return r;
    endfunction

    // Start a fill and push n beats back to back; leaves the DUT mid-fill.
    task automatic partial(input logic [3:0] off, input logic [7:0] base, input int n);
        start = 1'b1;
        start_offset = off;
        beat_valid = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            beat_valid = 1'b1;
            beat_data = base + 8'(k);
            cyc();
        end
        beat_valid = 1'b0;
    endtask

    // Full fill; gap idle cycles between beats; noise drives start=1 with offset 9 throughout.
    task automatic run_fill(input logic [3:0] off, input logic [7:0] base, input int gap,
                            input bit noise, input string nm);
        int acc, cycn, ph, crit_n, done_n, crit_cyc, done_cyc;
        logic [15:0] m;
        logic [3:0]  idx;
        start = 1'b1;
        start_offset = off;
        beat_valid = 1'b0;
        cyc();
        cycn = 1;
        start = 1'b0;
        check({nm, "_busy"}, 128'(busy), 128'd1);
        acc = 0; ph = 0; crit_n = 0; done_n = 0; crit_cyc = 0; done_cyc = 0; m = '0;
        while (acc < 16) begin
            beat_valid = (ph == 0);
            beat_data = base + 8'(acc);
            start = noise;
            start_offset = 4'd9;
            if (acc == 0) begin
                #1;
                check({nm, "_ready"}, 128'(beat_ready), 128'd1);
            end
            cyc();
            cycn++;
            if (ph == 0) begin
                idx = 4'(int'(off) + acc);
                m[idx] = 1'b1;
                acc++;
                check({nm, "_mask"}, 128'(byte_mask), 128'(m));
            end
            ph = (ph == gap) ? 0 : ph + 1;
            if (crit_valid) begin
                crit_n++;
                crit_cyc = cycn;
                check({nm, "_crit_data"}, 128'(crit_data), 128'(base));
            end
            if (line_done) begin
                done_n++;
                done_cyc = cycn;
            end
        end
        start = noise;
        beat_valid = 1'b1;
        cyc();
        check({nm, "_done_low"}, 128'(line_done), 128'd0);
        check({nm, "_idle_after"}, 128'(busy), 128'd0);
        start = 1'b0;
        beat_valid = 1'b0;
        check({nm, "_crit_n"}, 128'(crit_n), 128'd1);
        check({nm, "_crit_cyc"}, 128'(crit_cyc), 128'd2);
        check({nm, "_done_n"}, 128'(done_n), 128'd1);
        check({nm, "_done_cyc"}, 128'(done_cyc), 128'(2 + 15 * (gap + 1)));
        check({nm, "_line"}, line_data, model_line(off, base));
        check({nm, "_mask_full"}, 128'(byte_mask), 128'hFFFF);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_offset = 4'd0;
        abort = 1'b0;
        beat_valid = 1'b1;
        beat_data = 8'h55;
        #12;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(beat_ready), 128'd0);
        check("rst_line", line_data, 128'd0);
        check("rst_mask", 128'(byte_mask), 128'd0);
        check("rst_crit", 128'({crit_valid, crit_data, line_done}), 128'd0);
        #1 rst_n = 1'b1;
        cyc();
        check("idle_ready", 128'(beat_ready), 128'd0);
        check("idle_ignore_beat", 128'(byte_mask), 128'd0);
        beat_valid = 1'b0;

        run_fill(4'd0, 8'h00, 0, 1'b0, "aligned");
        check("aligned_const", line_data, 128'h0F0E0D0C0B0A09080706050403020100);

        run_fill(4'd13, 8'hA0, 0, 1'b0, "wrap");
        check("wrap_l13", 128'(line_data[13*8 +: 8]), 128'hA0);
        check("wrap_l15", 128'(line_data[15*8 +: 8]), 128'hA2);
        check("wrap_l0", 128'(line_data[7:0]), 128'hA3);
        check("wrap_l12", 128'(line_data[12*8 +: 8]), 128'hAF);

        run_fill(4'd5, 8'h30, 2, 1'b0, "thr");
        check("thr_l4", 128'(line_data[4*8 +: 8]), 128'h3F);

        run_fill(4'd2, 8'hC0, 0, 1'b1, "noise");
        check("noise_l2", 128'(line_data[2*8 +: 8]), 128'hC0);
        check("noise_l10", 128'(line_data[10*8 +: 8]), 128'hC8);

        partial(4'd3, 8'h60, 7);
        check("abort_pre_mask", 128'(byte_mask), 128'h03F8);
        abort = 1'b1;
        beat_valid = 1'b1;
        beat_data = 8'h77;
        #1;
        check("abort_ready", 128'(beat_ready), 128'd0);
        cyc();
        abort = 1'b0;
        beat_valid = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_mask", 128'(byte_mask), 128'd0);
        check("abort_done", 128'(line_done), 128'd0);
        cyc();
        check("abort_done2", 128'(line_done), 128'd0);
        run_fill(4'd11, 8'hE0, 0, 1'b0, "post_abort");

        partial(4'd6, 8'h10, 15);
        abort = 1'b1;
        beat_valid = 1'b1;
        beat_data = 8'h1F;
        cyc();
        abort = 1'b0;
        beat_valid = 1'b0;
        check("abort_last_done", 128'(line_done), 128'd0);
        check("abort_last_mask", 128'(byte_mask), 128'd0);
        check("abort_last_busy", 128'(busy), 128'd0);
        cyc();
        check("abort_last_done2", 128'(line_done), 128'd0);

        abort = 1'b1;
        start = 1'b1;
        start_offset = 4'd0;
        cyc();
        start = 1'b0;
        check("idle_abort_start", 128'(busy), 128'd1);
        cyc();
        abort = 1'b0;
        check("fill_abort_idle", 128'(busy), 128'd0);

        partial(4'd2, 8'h50, 5);
        check("mid_crit", 128'(crit_data), 128'h50);
        beat_valid = 1'b1;
        beat_data = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_ready", 128'(beat_ready), 128'd0);
        check("mid_rst_line", line_data, 128'd0);
        check("mid_rst_mask", 128'(byte_mask), 128'd0);
        check("mid_rst_crit", 128'(crit_data), 128'd0);
        #2 rst_n = 1'b1;
        cyc();
        check("mid_rel_busy", 128'(busy), 128'd0);
        check("mid_rel_mask", 128'(byte_mask), 128'd0);
        beat_valid = 1'b0;

        run_fill(4'd7, 8'h40, 0, 1'b0, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
